// File: rtl/analog_status_reporter_pkg.sv
// Shared constants, state encoding and frame layout for the analog status reply path.
// Latency: n/a (declarations only).
// Backpressure: n/a. Frame length depends on STATUS_CHECKSUM_EN (6 bytes when defined, 5 otherwise).
package analog_status_reporter_pkg;

  // Command bytes seen on the shared command stream; only the query is acted on here.
  localparam logic [7:0] CMD_QUERY     = 8'd63;
  localparam logic [7:0] CMD_POWER_ON  = 8'd80;
  localparam logic [7:0] CMD_POWER_OFF = 8'd112;

  // Fixed frame delimiters.
  localparam logic [7:0] FRAME_HDR = 8'h53;
  localparam logic [7:0] FRAME_EOL = 8'h0A;

  // Bit positions inside the status byte.
  localparam int STAT_APE_BIT   = 0;
  localparam int STAT_OE_BIT    = 1;
  localparam int STAT_FAULT_BIT = 2;

`ifdef STATUS_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Values frozen at query time and replayed for the whole frame.
  typedef struct packed {
    logic [7:0]  status;
    logic [15:0] cnt;
  } snap_t;

  // Byte presented at a given frame index.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input snap_t s);
    logic [7:0] b;
    case (idx)
      3'd0:    b = FRAME_HDR;
      3'd1:    b = s.status;
      3'd2:    b = s.cnt[15:8];
      3'd3:    b = s.cnt[7:0];
`ifdef STATUS_CHECKSUM_EN
      3'd4:    b = s.status ^ s.cnt[15:8] ^ s.cnt[7:0];
`endif
      default: b = FRAME_EOL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/analog_status_reporter_power_on_timer.sv
// Prescaled saturating 16-bit on-time counter with power-enable edge detection.
// Latency: count updates one cycle after each prescaler wrap; fall_forced_o is combinational on the falling edge cycle.
// Backpressure: none; free-running whenever power is enabled, holds while power is off.
module analog_status_reporter_power_on_timer #(
  parameter int PRESCALE = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        apen_i,
  input  logic        oe_i,
  output logic [15:0] cnt_o,
  output logic        fall_forced_o
);

  localparam int PW = $clog2(PRESCALE);

  logic          apen_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          rise;

  assign rise = apen_i & ~apen_q;

  // A drop of power while the board output-enable is low is an uncommanded loss.
  assign fall_forced_o = apen_q & ~apen_i & ~oe_i;
  assign cnt_o         = cnt_q;

  // Prescaler and counter next state: restart on power-up, tick while powered, hold when off.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (rise) begin
      presc_d = '0;
      cnt_d   = 16'h0000;
    end else if (apen_i) begin
      if (presc_q == PW'(PRESCALE - 1)) begin
        presc_d = '0;
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      apen_q  <= 1'b0;
      presc_q <= '0;
      cnt_q   <= 16'h0000;
    end else begin
      apen_q  <= apen_i;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/analog_status_reporter.sv
// Answers the '?' query with a framed status report (hdr, status, cnt hi/lo, [chk when STATUS_CHECKSUM_EN], EOL).
// Latency: first byte valid the cycle after the query; one byte per cycle with TxReady high.
// Backpressure: TxData/TxValid held while TxReady is low; queries arriving mid-frame are dropped.
module analog_status_reporter
  import analog_status_reporter_pkg::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Cmd,
  input  logic       OutputEnable,
  input  logic       AnalogPowerEnable,
  output logic [7:0] TxData,
  output logic       TxValid,
  input  logic       TxReady,
  output logic       Busy
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  snap_t       snap_q, snap_d;
  logic        fault_q, fault_d;
  logic [15:0] cnt;
  logic        fall_forced;
  logic        query_accept;
  logic        xfer;

  analog_status_reporter_power_on_timer #(
    .PRESCALE(PRESCALE)
  ) u_power_on_timer (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .apen_i       (AnalogPowerEnable),
    .oe_i         (OutputEnable),
    .cnt_o        (cnt),
    .fall_forced_o(fall_forced)
  );

  assign query_accept = (state_q == IDLE) && (Cmd == CMD_QUERY);
  assign xfer         = (state_q == SEND) && TxReady;

  // Frame sequencing, snapshot capture and sticky fault update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    snap_d    = snap_q;
    fault_d   = fault_q;

    // Clear on snapshot, but a simultaneous forced drop must not be lost.
    if (query_accept) fault_d = 1'b0;
    if (fall_forced)  fault_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (query_accept) begin
          state_d                       = SEND;
          idx_d                         = 3'd0;
          tx_data_d                     = FRAME_HDR;
          snap_d.status                 = 8'h00;
          snap_d.status[STAT_FAULT_BIT] = fault_q;
          snap_d.status[STAT_OE_BIT]    = OutputEnable;
          snap_d.status[STAT_APE_BIT]   = AnalogPowerEnable;
          snap_d.cnt                    = cnt;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d   = IDLE;
            idx_d     = 3'd0;
            tx_data_d = 8'h00;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = frame_byte(idx_q + 3'd1, snap_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state; reset abandons any frame in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      tx_data_q <= 8'h00;
      snap_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      snap_q    <= snap_d;
      fault_q   <= fault_d;
    end
  end

  assign TxData  = tx_data_q;
  assign TxValid = (state_q == SEND);
  assign Busy    = (state_q == SEND);

endmodule

// File: tb/tb_analog_status_reporter.sv
// Directed bench for analog_status_reporter: two instances (PRESCALE=4 and PRESCALE=2).
// Latency: expects first byte one cycle after the query, then one byte per accepted cycle.
// Backpressure: exercises TxReady stalls, mid-frame queries and reset mid-frame.
module tb_analog_status_reporter;

`ifdef STATUS_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif

  logic       clk;
  logic       rst_a, rst_b;
  logic [7:0] cmd_a, cmd_b;
  logic       oe_a, oe_b, ape_a, ape_b, rdy_a, rdy_b;
  logic [7:0] txd_a, txd_b;
  logic       txv_a, txv_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  analog_status_reporter #(.PRESCALE(4)) dut_a (
    .Clock(clk), .Reset(rst_a), .Cmd(cmd_a), .OutputEnable(oe_a),
    .AnalogPowerEnable(ape_a), .TxData(txd_a), .TxValid(txv_a),
    .TxReady(rdy_a), .Busy(busy_a)
  );

  analog_status_reporter #(.PRESCALE(2)) dut_b (
    .Clock(clk), .Reset(rst_b), .Cmd(cmd_b), .OutputEnable(oe_b),
    .AnalogPowerEnable(ape_b), .TxData(txd_b), .TxValid(txv_b),
    .TxReady(rdy_b), .Busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-derived frame byte i for a given snapshot.
  function automatic logic [7:0] fexp(input logic [7:0] st, input logic [15:0] c, input int i);
    logic [7:0] b;
    if (i == 0)             b = 8'h53;
    else if (i == 1)        b = st;
    else if (i == 2)        b = c[15:8];
    else if (i == 3)        b = c[7:0];
    else if (i == FLEN - 1) b = 8'h0A;
    else                    b = st ^ c[15:8] ^ c[7:0];
    return b;
  endfunction

  // Walks a frame already started; with cnt_known=0 the count bytes are taken as observed
  // and only the status, delimiters and checksum consistency are checked.
  task automatic run_frame(input string tag, input bit b, input logic [7:0] st,
                           input logic [15:0] c, input bit cnt_known);
    logic [15:0] cc;
    logic [7:0]  obs;
    cc = c;
    for (int i = 0; i < FLEN; i++) begin
      obs = b ? txd_b : txd_a;
      chk($sformatf("%s_valid%0d", tag, i), b ? txv_b : txv_a, 16'd1);
      chk($sformatf("%s_busy%0d", tag, i), b ? busy_b : busy_a, 16'd1);
      if (!cnt_known && i == 2)      cc[15:8] = obs;
      else if (!cnt_known && i == 3) cc[7:0]  = obs;
      else chk($sformatf("%s_byte%0d", tag, i), obs, fexp(st, cc, i));
      step;
    end
    chk({tag, "_end_valid"}, b ? txv_b : txv_a, 16'd0);
    chk({tag, "_end_busy"}, b ? busy_b : busy_a, 16'd0);
  endtask

  initial begin
    rst_a = 1; rst_b = 1; cmd_a = 0; cmd_b = 0;
    oe_a = 0; oe_b = 0; ape_a = 0; ape_b = 0; rdy_a = 0; rdy_b = 0;
    step; step;
    chk("rst_txvalid", txv_a, 16'd0);
    chk("rst_txdata", txd_a, 16'h00);
    chk("rst_busy", busy_a, 16'd0);
    chk("rst_b_txvalid", txv_b, 16'd0);
    rst_a = 0; rst_b = 0; oe_a = 1; oe_b = 1; rdy_a = 1; rdy_b = 1;

    // t1: rise edge plus 40 powered edges at PRESCALE=4 -> cnt 10
    ape_a = 1;
    repeat (41) step;
    cmd_a = 8'd63; step; cmd_a = 0;
    run_frame("t1", 0, 8'h03, 16'h000A, 1);

    // t2: forced drop sets fault; first query reports and clears it
    oe_a = 0; ape_a = 0; step;
    cmd_a = 8'd63; step; cmd_a = 0;
    run_frame("t2a", 0, 8'h04, 16'h0000, 0);
    step;
    cmd_a = 8'd63; step; cmd_a = 0;
    run_frame("t2b", 0, 8'h00, 16'h0000, 0);

    // commanded off (OE high) leaves fault clear and cnt at 0
    oe_a = 1; ape_a = 1; step; ape_a = 0; step;

    // t3: TxReady low for 3 cycles while status byte is presented
    cmd_a = 8'd63; step; cmd_a = 0;
    chk("t3_b0", txd_a, 16'h53);
    step;
    chk("t3_b1", txd_a, 16'h02);
    rdy_a = 0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("t3_hold_valid%0d", k), txv_a, 16'd1);
      chk($sformatf("t3_hold_data%0d", k), txd_a, 16'h02);
    end
    rdy_a = 1;
    for (int i = 2; i < FLEN; i++) begin
      step;
      chk($sformatf("t3_b%0d", i), txd_a, fexp(8'h02, 16'h0000, i));
    end
    step;
    chk("t3_end_valid", txv_a, 16'd0);

    // t4: a second query mid-frame is dropped
    cmd_a = 8'd63; step; cmd_a = 0;
    for (int i = 0; i < FLEN; i++) begin
      chk($sformatf("t4_valid%0d", i), txv_a, 16'd1);
      chk($sformatf("t4_b%0d", i), txd_a, fexp(8'h02, 16'h0000, i));
      if (i == 1) cmd_a = 8'd63;
      step;
      cmd_a = 0;
    end
    chk("t4_end_busy", busy_a, 16'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_idle_valid%0d", k), txv_a, 16'd0);
      step;
    end

    // t5: cnt=5 after rise + 20 powered edges; reset while byte 3 is presented
    ape_a = 1; step;
    repeat (20) step;
    ape_a = 0; step;
    cmd_a = 8'd63; step; cmd_a = 0;
    chk("t5_b0", txd_a, 16'h53); step;
    chk("t5_b1", txd_a, 16'h02); step;
    chk("t5_b2", txd_a, 16'h00); step;
    chk("t5_b3", txd_a, 16'h05);
    rst_a = 1; step; rst_a = 0;
    chk("t5_rst_valid", txv_a, 16'd0);
    chk("t5_rst_busy", busy_a, 16'd0);
    chk("t5_rst_data", txd_a, 16'h00);
    step;
    cmd_a = 8'd63; step; cmd_a = 0;
    run_frame("t5", 0, 8'h02, 16'h0000, 1);

    // t6: PRESCALE=2 counter saturates, then restarts on the next power-up
    ape_b = 1; step;
    repeat (131080) step;
    cmd_b = 8'd63; step; cmd_b = 0;
    run_frame("t6a", 1, 8'h03, 16'hFFFF, 1);
    ape_b = 0; step;
    ape_b = 1; step;
    repeat (6) step;
    cmd_b = 8'd63; step; cmd_b = 0;
    run_frame("t6b", 1, 8'h03, 16'h0003, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
